// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer placing two requesters (m0 core load/store,
// m1 DMA/loader) in front of the word-addressed data memory, with a registered response per port.
module dmem_arbiter #(
   parameter int unsigned ACCESS_CYCLES = 1,
   parameter int unsigned MEM_BYTES     = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_OWN  = 1'b1;

   localparam int unsigned      CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

   logic [0:0]       state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_owner_q, last_owner_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       ack_q, ack_d;
   logic [1:0]       err_q, err_d;
   logic [31:0]      rdata0_q, rdata0_d;
   logic [31:0]      rdata1_q, rdata1_d;

   logic [1:0] elig;
   logic       bad;
   logic       last_cycle;
   logic       grant;
   logic       grant_id;

   // The registered ack hides a request that is still high during its own ack cycle.
   assign elig       = {m1_req, m0_req} & ~ack_q;
   assign bad        = (addr_q >= MEM_BYTES) | (addr_q[1:0] != 2'b00);
   assign last_cycle = (state_q == S_OWN) && (cnt_q == '0);

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      ack_d        = 2'b00;
      err_d        = 2'b00;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      grant        = 1'b0;
      grant_id     = 1'b0;

      if (state_q == S_IDLE) begin
         if (elig == 2'b11) begin
            grant    = 1'b1;
            grant_id = ~last_owner_q;
         end else if (elig != 2'b00) begin
            grant    = 1'b1;
            grant_id = elig[1];
         end
      end else if (last_cycle) begin
         ack_d[owner_q] = 1'b1;
         err_d[owner_q] = bad;
         if (owner_q) rdata1_d = mem_read ? mem_read_data : 32'h0;
         else         rdata0_d = mem_read ? mem_read_data : 32'h0;
         state_d = S_IDLE;
         // Hand straight over to the other port; the finishing owner is never regranted here.
         if (elig[~owner_q]) begin
            grant    = 1'b1;
            grant_id = ~owner_q;
         end
      end else begin
         cnt_d = cnt_q - 1'b1;
      end

      if (grant) begin
         state_d      = S_OWN;
         owner_d      = grant_id;
         last_owner_d = grant_id;
         we_d         = grant_id ? m1_we    : m0_we;
         addr_d       = grant_id ? m1_addr  : m0_addr;
         wdata_d      = grant_id ? m1_wdata : m0_wdata;
         cnt_d        = CNT_LOAD;
      end
   end

   // NOTE: registers use non-blocking assignments so they all update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         cnt_q        <= '0;
         ack_q        <= 2'b00;
         err_q        <= 2'b00;
         rdata0_q     <= 32'h0;
         rdata1_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   // A write strobes only in the final cycle so each access writes exactly once.
   assign mem_read       = (state_q == S_OWN) & ~we_q & ~bad;
   assign mem_write      = last_cycle & we_q & ~bad;
   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;

   assign m0_ack   = ack_q[0];
   assign m0_err   = err_q[0];
   assign m0_rdata = rdata0_q;
   assign m1_ack   = ack_q[1];
   assign m1_err   = err_q[1];
   assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance 0 runs ACCESS_CYCLES=1, instance 1 ACCESS_CYCLES=3,
// each in front of its own word-array memory model.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n          [2];
   logic        m0_req         [2];
   logic        m0_we          [2];
   logic [31:0] m0_addr        [2];
   logic [31:0] m0_wdata       [2];
   logic        m0_ack         [2];
   logic        m0_err         [2];
   logic [31:0] m0_rdata       [2];
   logic        m1_req         [2];
   logic        m1_we          [2];
   logic [31:0] m1_addr        [2];
   logic [31:0] m1_wdata       [2];
   logic        m1_ack         [2];
   logic        m1_err         [2];
   logic [31:0] m1_rdata       [2];
   logic        mem_read       [2];
   logic        mem_write      [2];
   logic [31:0] mem_address    [2];
   logic [31:0] mem_write_data [2];
   logic [31:0] mem_read_data  [2];

   logic [31:0] mem0 [4096];
   logic [31:0] mem1 [4096];
   int          wr_cnt0 = 0;
   int          wr_cnt1 = 0;

   int n_checks = 0;
   int n_fail   = 0;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      dmem_arbiter #(
         .ACCESS_CYCLES(k == 0 ? 1 : 3),
         .MEM_BYTES    (16384)
      ) u_dut (
         .clk           (clk),
         .rst_n         (rst_n[k]),
         .m0_req        (m0_req[k]),
         .m0_we         (m0_we[k]),
         .m0_addr       (m0_addr[k]),
         .m0_wdata      (m0_wdata[k]),
         .m0_ack        (m0_ack[k]),
         .m0_err        (m0_err[k]),
         .m0_rdata      (m0_rdata[k]),
         .m1_req        (m1_req[k]),
         .m1_we         (m1_we[k]),
         .m1_addr       (m1_addr[k]),
         .m1_wdata      (m1_wdata[k]),
         .m1_ack        (m1_ack[k]),
         .m1_err        (m1_err[k]),
         .m1_rdata      (m1_rdata[k]),
         .mem_read      (mem_read[k]),
         .mem_write     (mem_write[k]),
         .mem_address   (mem_address[k]),
         .mem_write_data(mem_write_data[k]),
         .mem_read_data (mem_read_data[k])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: combinational read, write on the rising edge, writes counted.
   assign mem_read_data[0] = mem0[mem_address[0][13:2]];
   assign mem_read_data[1] = mem1[mem_address[1][13:2]];

   always @(posedge clk) begin
      if (mem_write[0]) begin
         mem0[mem_address[0][13:2]] <= mem_write_data[0];
         wr_cnt0 <= wr_cnt0 + 1;
      end
      if (mem_write[1]) begin
         mem1[mem_address[1][13:2]] <= mem_write_data[1];
         wr_cnt1 <= wr_cnt1 + 1;
      end
   end

   task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive_m0(input int k, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
      m0_req[k]   = req;
      m0_we[k]    = we;
      m0_addr[k]  = addr;
      m0_wdata[k] = wdata;
   endtask

   task automatic drive_m1(input int k, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
      m1_req[k]   = req;
      m1_we[k]    = we;
      m1_addr[k]  = addr;
      m1_wdata[k] = wdata;
   endtask

   logic [31:0] exp_addr [6];
   logic [5:0]  exp_rd;
   logic [5:0]  exp_ack0;
   logic [5:0]  exp_ack1;

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem0[i] = 32'hA000_0000 + 32'(i);
         mem1[i] = 32'hA000_0000 + 32'(i);
      end
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0;
         drive_m0(k, 1'b0, 1'b0, 32'h0, 32'h0);
         drive_m1(k, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      repeat (2) cyc();
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      // Reset state of both instances.
      for (int k = 0; k < 2; k++) begin
         check_b("rst_m0_ack", m0_ack[k], 1'b0);
         check_b("rst_m1_err", m1_err[k], 1'b0);
         check_w("rst_m0_rdata", m0_rdata[k], 32'h0);
         check_b("rst_mem_read", mem_read[k], 1'b0);
         check_b("rst_mem_write", mem_write[k], 1'b0);
         check_w("rst_mem_address", mem_address[k], 32'h0);
         check_w("rst_mem_wdata", mem_write_data[k], 32'h0);
      end

      // m0 write then read back, ACCESS_CYCLES=1.
      drive_m0(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      cyc();
      check_b("t1_wr_strobe", mem_write[0], 1'b1);
      check_w("t1_wr_addr", mem_address[0], 32'h10);
      check_w("t1_wr_data", mem_write_data[0], 32'hDEAD_BEEF);
      check_b("t1_wr_noack", m0_ack[0], 1'b0);
      cyc();
      check_b("t1_wr_ack", m0_ack[0], 1'b1);
      check_b("t1_wr_err", m0_err[0], 1'b0);
      check_b("t1_wr_once", mem_write[0], 1'b0);
      drive_m0(0, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
      drive_m0(0, 1'b1, 1'b0, 32'h10, 32'h0);
      cyc();
      check_b("t1_rd_strobe", mem_read[0], 1'b1);
      check_b("t1_rd_nowrite", mem_write[0], 1'b0);
      check_b("t1_rd_noack", m0_ack[0], 1'b0);
      cyc();
      check_b("t1_rd_ack", m0_ack[0], 1'b1);
      check_w("t1_rd_data", m0_rdata[0], 32'hDEAD_BEEF);
      check_b("t1_rd_err", m0_err[0], 1'b0);
      drive_m0(0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_w("t1_write_count", wr_cnt0, 32'd1);
      check_w("t1_mem_word", mem0[4], 32'hDEAD_BEEF);

      // m0 back-to-back reads with m1 idle: one IDLE cycle between accesses.
      cyc();
      drive_m0(0, 1'b1, 1'b0, 32'h0, 32'h0);
      cyc();
      check_b("t6_rd0_strobe", mem_read[0], 1'b1);
      check_w("t6_rd0_addr", mem_address[0], 32'h0);
      cyc();
      check_b("t6_rd0_ack", m0_ack[0], 1'b1);
      check_w("t6_rd0_data", m0_rdata[0], 32'hA000_0000);
      drive_m0(0, 1'b1, 1'b0, 32'h4, 32'h0);
      cyc();
      check_b("t6_bubble_rd", mem_read[0], 1'b0);
      check_b("t6_bubble_ack", m0_ack[0], 1'b0);
      cyc();
      check_b("t6_rd1_strobe", mem_read[0], 1'b1);
      check_w("t6_rd1_addr", mem_address[0], 32'h4);
      check_b("t6_rd1_noack", m0_ack[0], 1'b0);
      cyc();
      check_b("t6_rd1_ack", m0_ack[0], 1'b1);
      check_w("t6_rd1_data", m0_rdata[0], 32'hA000_0001);
      drive_m0(0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Fresh reset, then both ports read continuously: grants m0,m1,m0,m1.
      cyc();
      rst_n[0] = 1'b0;
      cyc();
      check_w("t2_rst_rdata", m0_rdata[0], 32'h0);
      rst_n[0] = 1'b1;
      drive_m0(0, 1'b1, 1'b0, 32'h20, 32'h0);
      drive_m1(0, 1'b1, 1'b0, 32'h40, 32'h0);
      exp_addr = '{32'h20, 32'h40, 32'h40, 32'h20, 32'h40, 32'h40};
      exp_rd   = 6'b011011;
      exp_ack0 = 6'b010010;
      exp_ack1 = 6'b100100;
      for (int t = 0; t < 6; t++) begin
         cyc();
         check_w($sformatf("t2_addr_c%0d", t + 1), mem_address[0], exp_addr[t]);
         check_b($sformatf("t2_rd_c%0d", t + 1), mem_read[0], exp_rd[t]);
         check_b($sformatf("t2_ack0_c%0d", t + 1), m0_ack[0], exp_ack0[t]);
         check_b($sformatf("t2_ack1_c%0d", t + 1), m1_ack[0], exp_ack1[t]);
         if (t == 1) check_w("t2_m0_data", m0_rdata[0], 32'hA000_0008);
         if (t == 2) check_w("t2_m1_data", m1_rdata[0], 32'hA000_0010);
         if (t == 4) drive_m0(0, 1'b0, 1'b0, 32'h0, 32'h0);
         if (t == 5) drive_m1(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end

      // m1 out-of-range read and misaligned write are rejected.
      cyc();
      drive_m1(0, 1'b1, 1'b0, 32'h4000, 32'h0);
      cyc();
      check_b("t3_oob_noread", mem_read[0], 1'b0);
      check_b("t3_oob_nowrite", mem_write[0], 1'b0);
      cyc();
      check_b("t3_oob_ack", m1_ack[0], 1'b1);
      check_b("t3_oob_err", m1_err[0], 1'b1);
      check_w("t3_oob_rdata", m1_rdata[0], 32'h0);
      drive_m1(0, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
      drive_m1(0, 1'b1, 1'b1, 32'h22, 32'hFFFF_FFFF);
      cyc();
      check_b("t3_mis_nowrite", mem_write[0], 1'b0);
      check_b("t3_mis_noread", mem_read[0], 1'b0);
      cyc();
      check_b("t3_mis_ack", m1_ack[0], 1'b1);
      check_b("t3_mis_err", m1_err[0], 1'b1);
      check_w("t3_mis_rdata", m1_rdata[0], 32'h0);
      drive_m1(0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_w("t3_write_count", wr_cnt0, 32'd1);
      check_w("t3_mem_word", mem0[8], 32'hA000_0008);

      // ACCESS_CYCLES=3: m1 write holds the address three cycles, strobes in the third.
      drive_m1(1, 1'b1, 1'b1, 32'h8, 32'h1234_5678);
      for (int t = 1; t <= 4; t++) begin
         cyc();
         if (t <= 3) check_w($sformatf("t4_addr_c%0d", t), mem_address[1], 32'h8);
         check_b($sformatf("t4_wr_c%0d", t), mem_write[1], t == 3);
         check_b($sformatf("t4_ack_c%0d", t), m1_ack[1], t == 4);
      end
      check_b("t4_err", m1_err[1], 1'b0);
      check_w("t4_rdata", m1_rdata[1], 32'h0);
      drive_m1(1, 1'b0, 1'b0, 32'h0, 32'h0);
      check_w("t4_mem_word", mem1[2], 32'h1234_5678);
      check_w("t4_write_count", wr_cnt1, 32'd1);

      // Reset in the second OWN cycle of an m0 write aborts it; the next tie goes to m0.
      cyc();
      drive_m0(1, 1'b1, 1'b1, 32'hC, 32'hCAFE_F00D);
      cyc();
      check_w("t5_own_addr", mem_address[1], 32'hC);
      check_b("t5_own_nowrite", mem_write[1], 1'b0);
      cyc();
      rst_n[1] = 1'b0;
      drive_m0(1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check_w("t5_rst_addr", mem_address[1], 32'h0);
      check_b("t5_rst_nowrite", mem_write[1], 1'b0);
      cyc();
      cyc();
      check_b("t5_rst_noack", m0_ack[1], 1'b0);
      rst_n[1] = 1'b1;
      cyc();
      check_b("t5_post_noack", m0_ack[1], 1'b0);
      check_w("t5_write_count", wr_cnt1, 32'd1);
      check_w("t5_mem_word", mem1[3], 32'hA000_0003);
      drive_m0(1, 1'b1, 1'b0, 32'h10, 32'h0);
      drive_m1(1, 1'b1, 1'b0, 32'h14, 32'h0);
      cyc();
      check_w("t5_tie_addr", mem_address[1], 32'h10);
      check_b("t5_tie_rd", mem_read[1], 1'b1);
      repeat (3) cyc();
      check_b("t5_m0_ack", m0_ack[1], 1'b1);
      check_w("t5_m0_data", m0_rdata[1], 32'hA000_0004);
      check_w("t5_m1_addr", mem_address[1], 32'h14);
      drive_m0(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) cyc();
      check_b("t5_m1_ack", m1_ack[1], 1'b1);
      check_w("t5_m1_data", m1_rdata[1], 32'hA000_0005);
      drive_m1(1, 1'b0, 1'b0, 32'h0, 32'h0);

      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
